// File: rtl/pcie_wr_framer.sv
// Purpose: frames buffered 64-bit payload words into 128-byte PCIe memory-write TLPs (18 words each).
// Latency: o_valid rises one cycle after a page is held and 16 words are buffered; one word per o_ready.
// Backpressure: in_ready drops while the buffer is full; a missing o_ready holds state and o_data.
module pcie_wr_framer #(
  parameter int ABITS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pcie_id,
  input  logic        pg_valid,
  input  logic [63:0] pg_addr,
  output logic        pg_ready,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [65:0] o_data,
  output logic        page_done
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] TLP_WORDS = (ABITS+1)'(16);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

  state_t            state, state_nxt;
  logic [3:0]        idx, idx_nxt;
  logic [65:0]       data_nxt;

  logic [63:0]       mem [DEPTH];
  logic [ABITS-1:0]  wr_ptr, rd_ptr;
  logic [ABITS:0]    count, count_nxt;
  logic [63:0]       page;
  logic              held;
  logic [4:0]        n;

  logic              addr64, push, pop, done, release_pg, held_after;
  logic [63:0]       tlp_addr, head;
  logic [65:0]       hdr0_word;

  // Pages with a nonzero upper address half need the 4-DW header form.
  assign addr64     = (page[63:32] != 32'd0);
  assign tlp_addr   = page + {52'd0, n, 7'd0};
  assign hdr0_word  = {2'b00, pcie_id, 8'h00, 8'hFF, addr64 ? 32'h6000_0020 : 32'h4000_0020};

  // Count never exceeds DEPTH, so its top bit alone flags a full buffer.
  assign in_ready   = ~count[ABITS];
  assign push       = in_valid && in_ready;

  // A buffer word is released once its last emitted half is consumed. In the 3-DW form
  // the first word leaves with header word1 and the final word feeds both word16 and word17.
  assign pop        = o_ready && (((state == HDR1) && !addr64) ||
                                  ((state == DATA) && (addr64 || (idx != 4'd14))));
  assign done       = o_ready && (state == DATA) && (idx == 4'd15);
  assign release_pg = done && (n == 5'd31);
  assign held_after = held && !release_pg;
  assign count_nxt  = count + (ABITS+1)'(push) - (ABITS+1)'(pop);

  // Buffer head as it will stand after this cycle's pop: the source of the next data word.
  assign head       = mem[rd_ptr + ABITS'(pop)];

  // Next-state and next output word; back-to-back TLPs skip IDLE when enough data is waiting.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = o_data;
    case (state)
      IDLE: begin
        data_nxt = '0;
        if (held && (count >= TLP_WORDS)) begin
          state_nxt = HDR0;
          data_nxt  = hdr0_word;
        end
      end
      HDR0: if (o_ready) begin
        state_nxt = HDR1;
        data_nxt  = addr64 ? {2'b00, tlp_addr[31:0], tlp_addr[63:32]}
                           : {2'b00, head[31:0], tlp_addr[31:0]};
      end
      HDR1: if (o_ready) begin
        state_nxt = DATA;
        idx_nxt   = '0;
        data_nxt  = {2'b00, head};
      end
      DATA: if (o_ready) begin
        if (idx == 4'd15) begin
          idx_nxt = '0;
          if (held_after && (count_nxt >= TLP_WORDS)) begin
            state_nxt = HDR0;
            data_nxt  = hdr0_word;
          end else begin
            state_nxt = IDLE;
            data_nxt  = '0;
          end
        end else begin
          idx_nxt = idx + 4'd1;
          if (idx == 4'd14)
            data_nxt = addr64 ? {2'b01, head} : {2'b11, head[63:32], head[63:32]};
          else
            data_nxt = {2'b00, head};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register together with the registered output word and valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      o_data  <= data_nxt;
      o_valid <= (state_nxt != IDLE);
    end
  end

  // Buffer pointers, page ownership, packet counter and the one-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      page      <= '0;
      held      <= 1'b0;
      n         <= '0;
      pg_ready  <= 1'b0;
      page_done <= 1'b0;
    end else begin
      pg_ready  <= 1'b0;
      page_done <= release_pg;
      count     <= count_nxt;
      if (push) wr_ptr <= wr_ptr + ABITS'(1);
      if (pop)  rd_ptr <= rd_ptr + ABITS'(1);
      if (done) n <= n + 5'd1;
      if (release_pg) begin
        held <= 1'b0;
      end else if (!held && pg_valid) begin
        held     <= 1'b1;
        page     <= pg_addr;
        pg_ready <= 1'b1;
      end
    end
  end

  // Payload storage; occupancy is tracked by count, so the array needs no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pcie_wr_framer.sv
// Purpose: scoreboard bench for pcie_wr_framer; expected TLP words are queued as payload is driven.
// Latency: words are compared at the falling edge before the rising edge that consumes them.
// Backpressure: o_ready is either held high or toggled randomly; in_ready is honoured by the feeder.
module tb_pcie_wr_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pcie_id;
  logic        pg_valid;
  logic [63:0] pg_addr;
  logic        pg_ready;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        o_valid;
  logic        o_ready;
  logic [65:0] o_data;
  logic        page_done;

  localparam logic [63:0] P1 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] P2 = 64'h0000_0000_8000_0000;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pgr_cnt = 0;
  int          pd_cnt = 0;
  int          widx = 0;
  bit          mon_en = 1'b1;
  bit          rdy_mode = 1'b0;
  logic [65:0] exp_q [$];
  logic [63:0] dat [16];
  logic [65:0] cap_w0, cap_w1, cap_w17;

  pcie_wr_framer #(.ABITS(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .pcie_id   (pcie_id),
    .pg_valid  (pg_valid),
    .pg_addr   (pg_addr),
    .pg_ready  (pg_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .page_done (page_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference framing of one TLP from the page, packet number and the 16 words in dat.
  task automatic push_tlp(input logic [63:0] pg, input int pkt);
    logic [63:0] a;
    a = pg + 64'(pkt) * 64'd128;
    if (pg[63:32] != 32'd0) begin
      exp_q.push_back({2'b00, pcie_id, 8'h00, 8'hFF, 32'h6000_0020});
      exp_q.push_back({2'b00, a[31:0], a[63:32]});
      for (int k = 2; k <= 17; k++)
        exp_q.push_back({(k == 17) ? 2'b01 : 2'b00, dat[k-2]});
    end else begin
      exp_q.push_back({2'b00, pcie_id, 8'h00, 8'hFF, 32'h4000_0020});
      exp_q.push_back({2'b00, dat[0][31:0], a[31:0]});
      for (int k = 2; k <= 16; k++)
        exp_q.push_back({2'b00, dat[k-1]});
      exp_q.push_back({2'b11, dat[15][63:32], dat[15][63:32]});
    end
  endtask

  task automatic feed_word(input logic [63:0] w);
    int   waited;
    logic acc;
    waited   = 0;
    acc      = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    while (!acc && waited < 2000) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      waited++;
    end
    if (!acc) chk("feed_timeout", 66'(in_ready), 66'd1);
  endtask

  task automatic feed_all();
    for (int j = 0; j < 16; j++) feed_word(dat[j]);
    in_valid = 1'b0;
  endtask

  task automatic offer_page(input logic [63:0] a);
    int waited;
    waited   = 0;
    pg_addr  = a;
    pg_valid = 1'b1;
    while (!pg_ready && waited < 5000) begin
      @(posedge clock);
      #1;
      waited++;
    end
    chk("pg_ready_seen", 66'(pg_ready), 66'd1);
    pg_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < limit) begin
      @(posedge clock);
      #1;
      waited++;
    end
    chk("drain_left", 66'(exp_q.size()), 66'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // o_ready driver: always high, or a fair coin each cycle.
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      o_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pulse counters and scoreboard comparison of every consumed word.
  always @(negedge clock) begin
    logic [65:0] e;
    if (pg_ready)  pgr_cnt++;
    if (page_done) pd_cnt++;
    if (mon_en && o_valid && o_ready) begin
      chk("sb_nonempty", 66'(exp_q.size() != 0), 66'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tlp_word", o_data, e);
        if (widx == 0) cap_w0 = o_data;
        if (widx == 1) cap_w1 = o_data;
        if (e[64]) begin
          cap_w17 = o_data;
          widx    = 0;
        end else begin
          widx++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    logic found;
    reset    = 1'b1;
    pcie_id  = 16'h0100;
    pg_valid = 1'b0;
    pg_addr  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_o_valid",   66'(o_valid),   66'd0);
    chk("rst_o_data",    o_data,         66'd0);
    chk("rst_pg_ready",  66'(pg_ready),  66'd0);
    chk("rst_page_done", 66'(page_done), 66'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", 66'(in_ready), 66'd1);

    // 64-bit header page, o_ready high; 15 words must not start a TLP, the 16th must.
    offer_page(P1);
    for (int j = 0; j < 16; j++) dat[j] = 64'hCAFE_0000_0000_0000 + 64'(j);
    push_tlp(P1, 0);
    for (int j = 0; j < 15; j++) feed_word(dat[j]);
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("valid_at_15", 66'(o_valid), 66'd0);
    feed_word(dat[15]);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("valid_at_16", 66'(o_valid), 66'd1);
    chk("word0_64",    o_data, 66'h0_0100_00FF_6000_0020);
    drain(200);
    chk("word1_64",    cap_w1, 66'h0_0000_0000_0000_0001);
    chk("w17_flags",   66'(cap_w17[65:64]), 66'd1);

    // Remaining 31 TLPs of the page with random o_ready; next page offered meanwhile.
    rdy_mode = 1'b1;
    fork
      offer_page(P2);
    join_none
    for (int t = 1; t < 32; t++) begin
      for (int j = 0; j < 16; j++) dat[j] = {$urandom, $urandom};
      push_tlp(P1, t);
      feed_all();
    end
    drain(4000);
    chk("page_done_pulses", 66'(pd_cnt), 66'd1);
    waited = 0;
    while (pgr_cnt < 2 && waited < 200) begin
      @(posedge clock);
      #1;
      waited++;
    end
    chk("pg_ready_pulses", 66'(pgr_cnt), 66'd2);

    // 32-bit header page with DW index payload.
    rdy_mode = 1'b0;
    for (int j = 0; j < 16; j++) dat[j] = {32'(2*j+1), 32'(2*j)};
    push_tlp(P2, 0);
    feed_all();
    drain(200);
    chk("word1_32",  cap_w1,  66'h0_0000_0000_8000_0000);
    chk("word17_32", cap_w17, {2'b11, 32'd31, 32'd31});
    chk("idle_valid", 66'(o_valid), 66'd0);
    chk("idle_data",  o_data,       66'd0);

    // Reset while data word 7 is on the output.
    for (int j = 0; j < 16; j++) dat[j] = 64'hD00D_0000_0000_0000 + 64'(j);
    push_tlp(P2, 1);
    feed_all();
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 200) begin
      @(posedge clock);
      #1;
      waited++;
      found = o_valid && (o_data[63:0] == dat[8]);
    end
    chk("data7_reached", 66'(found), 66'd1);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_o_valid",   66'(o_valid),   66'd0);
    chk("mid_rst_o_data",    o_data,         66'd0);
    chk("mid_rst_pg_ready",  66'(pg_ready),  66'd0);
    chk("mid_rst_page_done", 66'(page_done), 66'd0);
    chk("mid_rst_in_ready",  66'(in_ready),  66'd1);
    exp_q.delete();
    widx   = 0;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clock);
    #1;

    // Clean TLP after reset must match the first one.
    offer_page(P1);
    for (int j = 0; j < 16; j++) dat[j] = 64'hCAFE_0000_0000_0000 + 64'(j);
    push_tlp(P1, 0);
    feed_all();
    drain(200);
    chk("rst_tlp_w0",    cap_w0, 66'h0_0100_00FF_6000_0020);
    chk("rst_tlp_w1",    cap_w1, 66'h0_0000_0000_0000_0001);
    chk("rst_tlp_flags", 66'(cap_w17[65:64]), 66'd1);
    chk("final_page_done_pulses", 66'(pd_cnt), 66'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
